// File: rtl/mem_responder_if.sv
// Fetch (ifu) and load/store (lsu) request/response bundle between the core
// and mem_responder. The core drives through the master modport; the
// responder uses the slave modport.
interface mem_responder_if;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;

  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;

  modport master (
    output ifu_reqValid, ifu_addr,
    output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    input  ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata
  );

  modport slave (
    input  ifu_reqValid, ifu_addr,
    input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    output ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-ported word memory serving the fetch and load/store
// ports, lsu having priority. Whole aligned words are returned; stores are
// byte-masked. Out-of-range accesses still respond (read 0, write dropped).
// Optional macro MEM_RAND_DELAY_EN adds 0-3 extra LFSR-driven cycles of
// latency per access.
//
// state | meaning
// IDLE  | waiting for a request; lsu wins a tie
// BUSY  | latency counter running down
// RESP  | owner's respValid high for this one cycle
module mem_responder #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 1
) (
  input logic clock,
  input logic reset,
  mem_responder_if.slave bus
);

  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN  = 32'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state, state_nx;
  logic [7:0]         cnt, cnt_nx;
  logic [7:0]         lat_eff;
  logic               accept, enter_resp;

  logic               acc_lsu, acc_in_range, acc_wen;
  logic [31:0]        acc_addr, acc_off;
  logic [IDX_W-1:0]   acc_idx;

  logic               owner_lsu, req_in_range, req_wen;
  logic [IDX_W-1:0]   req_idx;
  logic [3:0]         req_wmask;
  logic [31:0]        req_wdata;

  logic               cur_lsu, cur_in_range, cur_wen;
  logic [IDX_W-1:0]   cur_idx;
  logic [3:0]         cur_wmask;
  logic [31:0]        cur_wdata;

  logic [31:0]        ifu_rdata_q, lsu_rdata_q;
  logic [31:0]        mem [MEM_WORDS];

  // Size is informational; writes are governed by wmask alone.
  logic unused_size;
  assign unused_size = ^bus.lsu_size;

`ifdef MEM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Free-running x^8+x^6+x^5+x^4 LFSR supplying the random extra latency.
  always_ff @(posedge clock) begin
    if (!reset) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign lat_eff = 8'(LATENCY) + {6'd0, lfsr[1:0]};
`else
  assign lat_eff = 8'(LATENCY);
`endif

  // Arbitration, next-state and the access operands used when entering RESP.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    accept     = 1'b0;

    acc_lsu      = bus.lsu_reqValid;
    acc_addr     = acc_lsu ? bus.lsu_addr : bus.ifu_addr;
    acc_off      = acc_addr - BASE_ADDR;
    acc_in_range = (acc_off < SPAN);
    acc_idx      = acc_off[IDX_W+1:2];
    acc_wen      = acc_lsu & bus.lsu_wen;

    case (state)
      IDLE: begin
        if (bus.ifu_reqValid || bus.lsu_reqValid) begin
          accept   = 1'b1;
          cnt_nx   = lat_eff - 8'd1;
          state_nx = (lat_eff == 8'd1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_nx = cnt - 8'd1;
        if (cnt == 8'd1) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    enter_resp = (state != RESP) && (state_nx == RESP);

    // With a one-cycle latency RESP is entered at the acceptance edge, so the
    // live request is used; otherwise the captured request is.
    if (state == IDLE) begin
      cur_lsu      = acc_lsu;
      cur_in_range = acc_in_range;
      cur_wen      = acc_wen;
      cur_idx      = acc_idx;
      cur_wmask    = bus.lsu_wmask;
      cur_wdata    = bus.lsu_wdata;
    end else begin
      cur_lsu      = owner_lsu;
      cur_in_range = req_in_range;
      cur_wen      = req_wen;
      cur_idx      = req_idx;
      cur_wmask    = req_wmask;
      cur_wdata    = req_wdata;
    end
  end

  // FSM state and latency counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Capture the winning request at acceptance.
  always_ff @(posedge clock) begin
    if (!reset) begin
      owner_lsu    <= 1'b0;
      req_in_range <= 1'b0;
      req_wen      <= 1'b0;
      req_idx      <= '0;
      req_wmask    <= 4'd0;
      req_wdata    <= 32'd0;
    end else if (accept) begin
      owner_lsu    <= acc_lsu;
      req_in_range <= acc_in_range;
      req_wen      <= acc_wen;
      req_idx      <= acc_idx;
      req_wmask    <= bus.lsu_wmask;
      req_wdata    <= bus.lsu_wdata;
    end
  end

  // Read data into the owner's register; stores and out-of-range give 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ifu_rdata_q <= 32'd0;
      lsu_rdata_q <= 32'd0;
    end else if (enter_resp) begin
      if (cur_lsu)
        lsu_rdata_q <= (cur_wen || !cur_in_range) ? 32'd0 : mem[cur_idx];
      else
        ifu_rdata_q <= cur_in_range ? mem[cur_idx] : 32'd0;
    end
  end

  // Byte-masked store; contents survive reset, and reset aborts a pending write.
  always_ff @(posedge clock) begin
    if (reset && enter_resp && cur_wen && cur_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_wmask[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign bus.ifu_respValid = (state == RESP) && !owner_lsu;
  assign bus.lsu_respValid = (state == RESP) &&  owner_lsu;
  assign bus.ifu_rdata     = ifu_rdata_q;
  assign bus.lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 3, 4) share one set of
// stimulus signals; sel routes requests to one instance and picks its outputs.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        ifu_req, lsu_req, lsu_wen;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic [1:0]  lsu_size;

  logic        ifu_rv, lsu_rv;
  logic [31:0] ifu_rd, lsu_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_responder_if if_l1 ();
  mem_responder_if if_l3 ();
  mem_responder_if if_l4 ();

  mem_responder #(.LATENCY(1)) u_l1 (.clock(clock), .reset(rst_n), .bus(if_l1.slave));
  mem_responder #(.LATENCY(3)) u_l3 (.clock(clock), .reset(rst_n), .bus(if_l3.slave));
  mem_responder #(.LATENCY(4)) u_l4 (.clock(clock), .reset(rst_n), .bus(if_l4.slave));

  assign if_l1.ifu_reqValid = ifu_req && (sel == 2'd0);
  assign if_l1.lsu_reqValid = lsu_req && (sel == 2'd0);
  assign if_l1.ifu_addr = ifu_addr;  assign if_l1.lsu_addr  = lsu_addr;
  assign if_l1.lsu_size = lsu_size;  assign if_l1.lsu_wen   = lsu_wen;
  assign if_l1.lsu_wdata = lsu_wdata; assign if_l1.lsu_wmask = lsu_wmask;

  assign if_l3.ifu_reqValid = ifu_req && (sel == 2'd1);
  assign if_l3.lsu_reqValid = lsu_req && (sel == 2'd1);
  assign if_l3.ifu_addr = ifu_addr;  assign if_l3.lsu_addr  = lsu_addr;
  assign if_l3.lsu_size = lsu_size;  assign if_l3.lsu_wen   = lsu_wen;
  assign if_l3.lsu_wdata = lsu_wdata; assign if_l3.lsu_wmask = lsu_wmask;

  assign if_l4.ifu_reqValid = ifu_req && (sel == 2'd2);
  assign if_l4.lsu_reqValid = lsu_req && (sel == 2'd2);
  assign if_l4.ifu_addr = ifu_addr;  assign if_l4.lsu_addr  = lsu_addr;
  assign if_l4.lsu_size = lsu_size;  assign if_l4.lsu_wen   = lsu_wen;
  assign if_l4.lsu_wdata = lsu_wdata; assign if_l4.lsu_wmask = lsu_wmask;

  always_comb begin
    ifu_rv = if_l1.ifu_respValid; lsu_rv = if_l1.lsu_respValid;
    ifu_rd = if_l1.ifu_rdata;     lsu_rd = if_l1.lsu_rdata;
    if (sel == 2'd1) begin
      ifu_rv = if_l3.ifu_respValid; lsu_rv = if_l3.lsu_respValid;
      ifu_rd = if_l3.ifu_rdata;     lsu_rd = if_l3.lsu_rdata;
    end else if (sel == 2'd2) begin
      ifu_rv = if_l4.ifu_respValid; lsu_rv = if_l4.lsu_respValid;
      ifu_rd = if_l4.ifu_rdata;     lsu_rd = if_l4.lsu_rdata;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // One request on the selected instance; checks latency, data, strobe width
  // and that the other port stays quiet. Leaves the DUT in IDLE.
  task automatic do_req(input string name, input bit is_lsu, input logic [31:0] addr,
                        input bit wen, input logic [31:0] wd, input logic [3:0] wm,
                        input int exp_lat, input logic [31:0] exp_rd);
    int   seen;
    logic other;
    if (is_lsu) begin
      lsu_req = 1'b1; lsu_addr = addr; lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
    end else begin
      ifu_req = 1'b1; ifu_addr = addr;
    end
    step();
    lsu_req = 1'b0;
    ifu_req = 1'b0;
    seen  = 0;
    other = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (is_lsu ? ifu_rv : lsu_rv) other = 1'b1;
      if (is_lsu ? lsu_rv : ifu_rv) begin
        seen = k;
        break;
      end
      step();
    end
    check({name, " latency"}, 32'(seen), 32'(exp_lat));
    check({name, " rdata"}, is_lsu ? lsu_rd : ifu_rd, exp_rd);
    check({name, " other port quiet"}, {31'd0, other}, 32'd0);
    step();
    check({name, " strobe width"}, {31'd0, is_lsu ? lsu_rv : ifu_rv}, 32'd0);
  endtask

  typedef struct {
    string       name;
    bit          is_lsu;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          t_lsu, t_ifu, n_ifu, n_lsu, n_resp, k;
    logic        overlap;
    logic [31:0] ifu_d, lsu_d;
    int          times [3];
    logic [31:0] fa [4];
    logic [31:0] fexp [3];

    vecs[0]  = '{"st word",      1, 32'h8000_0010, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    vecs[1]  = '{"ld word",      1, 32'h8000_0010, 0, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    vecs[2]  = '{"st base20",    1, 32'h8000_0020, 1, 32'h1122_3344, 4'b1111, 32'h0};
    vecs[3]  = '{"st lane2",     1, 32'h8000_0020, 1, 32'h00AB_0000, 4'b0100, 32'h0};
    vecs[4]  = '{"ld unaligned", 1, 32'h8000_0022, 0, 32'h0,         4'b0000, 32'h11AB_3344};
    vecs[5]  = '{"st mask0",     1, 32'h8000_0020, 1, 32'hFFFF_FFFF, 4'b0000, 32'h0};
    vecs[6]  = '{"if after m0",  0, 32'h8000_0020, 0, 32'h0,         4'b0000, 32'h11AB_3344};
    vecs[7]  = '{"if oor zero",  0, 32'h0000_0000, 0, 32'h0,         4'b0000, 32'h0};
    vecs[8]  = '{"ld oor top",   1, 32'h8000_4000, 0, 32'h0,         4'b0000, 32'h0};
    vecs[9]  = '{"st word0",     1, 32'h8000_0000, 1, 32'h0102_0304, 4'b1111, 32'h0};
    vecs[10] = '{"st last",      1, 32'h8000_3FFC, 1, 32'hA5A5_A5A5, 4'b1111, 32'h0};
    vecs[11] = '{"st oor below", 1, 32'h7FFF_FFFC, 1, 32'h5555_5555, 4'b1111, 32'h0};
    vecs[12] = '{"st oor top",   1, 32'h8000_4000, 1, 32'h6666_6666, 4'b1111, 32'h0};
    vecs[13] = '{"ld last",      1, 32'h8000_3FFC, 0, 32'h0,         4'b0000, 32'hA5A5_A5A5};
    vecs[14] = '{"ld word0",     1, 32'h8000_0000, 0, 32'h0,         4'b0000, 32'h0102_0304};
    vecs[15] = '{"st lanes 0,3", 1, 32'h8000_0020, 1, 32'hEE00_00CC, 4'b1001, 32'h0};

    sel = 2'd0; rst_n = 1'b0;
    ifu_req = 1'b0; lsu_req = 1'b1; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    ifu_addr = 32'h8000_0000; lsu_addr = 32'h8000_0000; lsu_size = 2'b10;

    // Reset with a request held: nothing may respond.
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst lsu_rv held req", {31'd0, lsu_rv}, 32'd0);
    end
    lsu_req = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #0;
      check("rst ifu_rv",    {31'd0, ifu_rv}, 32'd0);
      check("rst lsu_rv",    {31'd0, lsu_rv}, 32'd0);
      check("rst ifu_rdata", ifu_rd, 32'd0);
      check("rst lsu_rdata", lsu_rd, 32'd0);
    end
    sel = 2'd0;
    step();
    rst_n = 1'b1;
    step();
    step();
    check("idle after rst", {30'd0, ifu_rv, lsu_rv}, 32'd0);

    // Table of single accesses on the LATENCY=1 instance.
    for (int i = 0; i < NV; i++)
      do_req(vecs[i].name, vecs[i].is_lsu, vecs[i].addr, vecs[i].wen,
             vecs[i].wdata, vecs[i].wmask, 1, vecs[i].exp_rd);
    do_req("ld lanes 0,3", 1, 32'h8000_0020, 0, 32'h0, 4'h0, 1, 32'hEEAB_33CC);

    // Simultaneous requests on LATENCY=3.
    sel = 2'd1;
    do_req("l3 st 100", 1, 32'h8000_0100, 1, 32'h0BAD_F00D, 4'hF, 3, 32'h0);
    do_req("l3 st 104", 1, 32'h8000_0104, 1, 32'h1234_5678, 4'hF, 3, 32'h0);
    ifu_req = 1'b1; ifu_addr = 32'h8000_0104;
    lsu_req = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b0; lsu_wmask = 4'h0;
    step();
    lsu_req = 1'b0;
    t_lsu = 0; t_ifu = 0; n_ifu = 0; n_lsu = 0; overlap = 1'b0;
    ifu_d = 32'h0; lsu_d = 32'h0;
    for (int t = 1; t <= 12; t++) begin
      if (ifu_rv && lsu_rv) overlap = 1'b1;
      if (lsu_rv) begin n_lsu++; if (t_lsu == 0) begin t_lsu = t; lsu_d = lsu_rd; end end
      if (ifu_rv) begin n_ifu++; if (t_ifu == 0) begin t_ifu = t; ifu_d = ifu_rd; end end
      if (t == 5) ifu_req = 1'b0;
      step();
    end
    check("tie lsu time",   32'(t_lsu), 32'd3);
    check("tie ifu time",   32'(t_ifu), 32'd7);
    check("tie lsu data",   lsu_d, 32'h0BAD_F00D);
    check("tie ifu data",   ifu_d, 32'h1234_5678);
    check("tie no overlap", {31'd0, overlap}, 32'd0);
    check("tie ifu count",  32'(n_ifu), 32'd1);
    check("tie lsu count",  32'(n_lsu), 32'd1);

    // Back-to-back fetch with reqValid held high.
    fa[0] = 32'h8000_0104; fa[1] = 32'h8000_0100; fa[2] = 32'h8000_0106; fa[3] = 32'h0;
    fexp[0] = 32'h1234_5678; fexp[1] = 32'h0BAD_F00D; fexp[2] = 32'h1234_5678;
    times[0] = 0; times[1] = 0; times[2] = 0;
    k = 0;
    ifu_addr = fa[0]; ifu_req = 1'b1;
    step();
    for (int t = 1; t <= 30 && k < 3; t++) begin
      if (ifu_rv) begin
        times[k] = t;
        check("b2b rdata", ifu_rd, fexp[k]);
        k++;
        ifu_addr = fa[k];
        if (k == 3) ifu_req = 1'b0;
      end
      step();
    end
    ifu_req = 1'b0;
    check("b2b count",  32'(k), 32'd3);
    check("b2b first",  32'(times[0]), 32'd3);
    check("b2b period", 32'(times[1] - times[0]), 32'd4);
    check("b2b period", 32'(times[2] - times[1]), 32'd4);
    step();

    // Reset during BUSY on LATENCY=4.
    sel = 2'd2;
    do_req("l4 clr 40", 1, 32'h8000_0040, 1, 32'h0,         4'hF, 4, 32'h0);
    do_req("l4 st 44",  1, 32'h8000_0044, 1, 32'h7777_7777, 4'hF, 4, 32'h0);
    do_req("l4 ld 44",  1, 32'h8000_0044, 0, 32'h0,         4'h0, 4, 32'h7777_7777);
    lsu_req = 1'b1; lsu_addr = 32'h8000_0040; lsu_wen = 1'b1;
    lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'hF;
    step();
    lsu_req = 1'b0;
    check("abort t1 no resp", {31'd0, lsu_rv}, 32'd0);
    step();
    check("abort t2 no resp", {31'd0, lsu_rv}, 32'd0);
    rst_n = 1'b0;
    step();
    check("abort rst resp",  {31'd0, lsu_rv}, 32'd0);
    check("abort rst lsu_rdata", lsu_rd, 32'd0);
    check("abort rst ifu_rdata", ifu_rd, 32'd0);
    rst_n = 1'b1;
    n_resp = 0;
    for (int t = 0; t < 6; t++) begin
      step();
      if (lsu_rv || ifu_rv) n_resp++;
    end
    check("abort no late resp", 32'(n_resp), 32'd0);
    do_req("abort ld 40", 1, 32'h8000_0040, 0, 32'h0, 4'h0, 4, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the core's instruction-fetch (ifu) and load/store (lsu) request/response interfaces.
- Backs both ports with one single-ported word-organised memory array and arbitrates between them.
- Returns whole aligned words, and applies byte-masked writes with lane-placed write data.
- Sits beside the core in the SoC and serves as the default memory for simulation and bring-up.

Parameters:
- MEM_WORDS, 4096: number of 32-bit words in the array.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 1: cycles from request acceptance to respValid. Must be at least 1.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-low reset
- ifu_reqValid  input  1  fetch request
- ifu_addr  input  32  fetch byte address
- ifu_respValid  output  1  fetch response strobe, one cycle wide
- ifu_rdata  output  32  fetched word
- lsu_reqValid  input  1  load/store request
- lsu_addr  input  32  load/store byte address
- lsu_size  input  2  access size: 00 byte, 01 half, 10 word. Informational only.
- lsu_wen  input  1  1 = store, 0 = load
- lsu_wdata  input  32  store data, already placed in byte lanes
- lsu_wmask  input  4  byte-lane write enables
- lsu_respValid  output  1  load/store response strobe, one cycle wide
- lsu_rdata  output  32  loaded word

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a clock edge):
  - FSM goes to IDLE; latency counter = 0.
  - ifu_respValid = 0, lsu_respValid = 0, ifu_rdata = 0, lsu_rdata = 0.
  - Memory contents are not cleared.
  - reqValid inputs are ignored while reset is low.
- FSM states:
  - IDLE: a request is accepted when either reqValid is high.
  - BUSY: the counter counts down.
  - RESP: exactly one respValid is high for one cycle.
- Arbitration in IDLE:
  - If both reqValid are high, lsu wins; the ifu request stays pending and is accepted in the next IDLE cycle.
  - The owner (ifu or lsu) is recorded at acceptance.
- Acceptance:
  - Register the owner, the word index ((addr - BASE_ADDR) >> 2), the in-range flag, wen, wmask and wdata.
  - Load the counter with LATENCY-1.
  - Transition: LATENCY==1 goes straight to RESP; otherwise go to BUSY.
- BUSY: decrement the counter each cycle. When the counter is 1, the next state is RESP.
- Memory access is performed at the edge that enters RESP:
  - Read: the addressed word is registered into the owner's rdata.
  - Write: update only the lanes with wmask[i]=1, using wdata[8i+7:8i]. lsu_rdata = 0 for stores.
- Timing:
  - Request accepted at edge N → respValid high during cycle N+LATENCY.
  - RESP returns to IDLE on the next edge.
  - The earliest next acceptance is at the end of cycle N+LATENCY+1.
- Requester rule:
  - Hold addr/wdata/wmask stable until respValid.
  - reqValid still high in the cycle after respValid is treated as a new request.
- rdata holds its value after the response until the next response to the same port.
- Alignment: address bits [1:0] are ignored. Reads return the full aligned word; the requester extracts lanes.
- lsu_size does not affect behaviour; writes are governed by wmask alone.
- wmask == 0 store: a response is given and memory is unchanged.
- Out-of-range address (addr < BASE_ADDR, or addr ≥ BASE_ADDR + 4*MEM_WORDS): read data = 32'h0, write dropped, response still given with normal latency. The port never hangs.
- Index arithmetic: 32-bit unsigned subtraction. Wrap-around below BASE_ADDR counts as out of range.
- Reset during BUSY: the pending access is aborted with no write committed and no response issued.
- Reset during RESP: respValid drops at that edge; an already-committed write stays.

Optional Feature:
- Macro: MEM_RAND_DELAY_EN.
- With the macro defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded with 8'hA5 on reset, advances every cycle.
  - On acceptance, the effective latency = LATENCY + lfsr[1:0], i.e. 0–3 extra cycles.
  - All handshake rules are unchanged.
- Without the macro: no LFSR logic; latency is exactly LATENCY.

Test Plan:
- Word store then load, LATENCY=1:
  - Store: lsu_wen=1, addr 0x8000_0010, wmask 4'b1111, wdata 0xDEADBEEF → lsu_respValid high exactly 1 cycle after acceptance.
  - Then load from 0x8000_0010 → lsu_rdata = 0xDEADBEEF.
- Byte-lane writes:
  - Word 0x8000_0020 holds 0x11223344.
  - Store wmask 4'b0100, wdata 0x00AB0000 → a subsequent read returns 0x11AB3344.
  - Store wmask 0 → the word is unchanged and a response is still given.
- Simultaneous requests: ifu_reqValid and lsu_reqValid rise in the same cycle, LATENCY=3 →
  - lsu_respValid is high at acceptance+3.
  - The ifu request is accepted in the cycle after that RESP, and ifu_respValid follows 3 cycles later.
  - The two respValid strobes never overlap.
- Out of range: fetch from 0x0000_0000, and load from BASE_ADDR + 4*MEM_WORDS → rdata 0 and a normal response. A store to 0x7FFF_FFFC → no memory word changes.
- Reset mid-operation, LATENCY=4:
  - Store 0xCAFEF00D to 0x8000_0040 (prior contents 0x0); pull reset low 2 cycles after acceptance.
  - Required: no lsu_respValid; a later read returns 0x0; after reset, respValid and rdata are 0.
- Back-to-back fetch with reqValid held high continuously → one response every LATENCY+1 cycles, and ifu_rdata tracks each new address.
